// File: rtl/xt_kbd_controller.sv
// XT keyboard port controller: queues set-1 scancodes and presents them one at a time
// on port 60h with IRQ1, releasing the next code after a port 61h bit-7 acknowledge.
module xt_kbd_controller #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iCodeValid,
    input  logic [7:0]    iCode,
    input  logic [19:0]   iAddr,
    input  logic          iRd,
    input  logic          iWr,
    input  logic [7:0]    iWrData,
    output logic          oSel,
    output logic [7:0]    oData,
    output logic          oIrq,
    output logic          oOverflow,
    output logic [CW-1:0] oCount
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      latch_q, latch_d;
    logic            irq_q, irq_d;
    logic            sel_q, sel_d;
    logic            ovf_q, ovf_d;

    logic            ack_c, ack_set_c, ack_clr_c;
    logic            full_c, empty_c;
    logic            push_c, pop_c;
    logic            unused_c;

    // Only the low 12 address bits and write-data bit 7 matter to this block.
    assign unused_c  = ^{iAddr[19:12], iWrData[6:0]};

    assign ack_c     = iWr && (iAddr[11:0] == 12'h061);
    assign ack_set_c = ack_c && iWrData[7];
    assign ack_clr_c = ack_c && !iWrData[7];
    assign full_c    = (count_q == CW'(DEPTH));
    assign empty_c   = (count_q == '0);

    // Next-state, FIFO bookkeeping and output decode.
    always_comb begin
        state_d  = state_q;
        latch_d  = latch_q;
        pop_c    = 1'b0;
        push_c   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_d    = 1'b0;
        sel_d    = 1'b0;

        // The head is popped into the latch on the edge that enters LOAD.
        case (state_q)
            ST_IDLE: begin
                if (ack_set_c) begin
                    state_d = ST_HOLD;
                end else if (!empty_c) begin
                    state_d = ST_LOAD;
                    pop_c   = 1'b1;
                    latch_d = mem_q[rd_ptr_q];
                end
            end
            ST_LOAD: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (ack_set_c) begin
                    state_d = ST_HOLD;
                    latch_d = 8'h00;
                end
            end
            ST_HOLD: begin
                latch_d = 8'h00;
                if (ack_clr_c) begin
                    if (!empty_c) begin
                        state_d = ST_LOAD;
                        pop_c   = 1'b1;
                        latch_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                latch_d = 8'h00;
            end
        endcase

        push_c = iCodeValid && (!full_c || pop_c);
        if (iCodeValid && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        irq_d = (state_d == ST_PRESENT);
        sel_d = iRd && (iAddr[11:0] == 12'h060);
    end

    // State and control registers; reset overrides everything.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            latch_q  <= 8'h00;
            irq_q    <= 1'b0;
            sel_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            latch_q  <= latch_d;
            irq_q    <= irq_d;
            sel_q    <= sel_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge iClk) begin
        if (!iRst && push_c) begin
            mem_q[wr_ptr_q] <= iCode;
        end
    end

    assign oSel      = sel_q;
    assign oData     = latch_q;
    assign oIrq      = irq_q;
    assign oOverflow = ovf_q;
    assign oCount    = count_q;

endmodule

// File: tb/tb_xt_kbd_controller.sv
// Directed bench for xt_kbd_controller: latency, queueing, overflow, push/pop, reset, decode.
module tb_xt_kbd_controller;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          code_valid;
    logic [7:0]    code;
    logic [19:0]   addr;
    logic          rd;
    logic          wr;
    logic [7:0]    wr_data;
    logic          sel;
    logic [7:0]    data;
    logic          irq;
    logic          ovf;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_codes [8];

    xt_kbd_controller #(.DEPTH(DEPTH)) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iCodeValid (code_valid),
        .iCode      (code),
        .iAddr      (addr),
        .iRd        (rd),
        .iWr        (wr),
        .iWrData    (wr_data),
        .oSel       (sel),
        .oData      (data),
        .oIrq       (irq),
        .oOverflow  (ovf),
        .oCount     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] c);
        code_valid = 1'b1;
        code       = c;
        step();
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic wr_port(input logic [19:0] a, input logic [7:0] d);
        wr      = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        wr      = 1'b0;
        addr    = '0;
        wr_data = 8'h00;
    endtask

    task automatic rd_port(input logic [19:0] a);
        rd   = 1'b1;
        addr = a;
        step();
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   32'(sel),   32'h0);
        chk({tag, "_data"},  32'(data),  32'h00);
        chk({tag, "_irq"},   32'(irq),   32'h0);
        chk({tag, "_ovf"},   32'(ovf),   32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        addr       = '0;
        rd         = 1'b0;
        wr         = 1'b0;
        wr_data    = 8'h00;
        step();
        step();
        rst = 1'b0;
        chk_reset_vals("rst");

        // Single key: latency N+1 / N+2 / N+3
        strobe(8'h1E);
        chk("sk_n1_count", 32'(count), 32'd1);
        chk("sk_n1_irq",   32'(irq),   32'h0);
        step();
        chk("sk_n2_count", 32'(count), 32'd0);
        chk("sk_n2_irq",   32'(irq),   32'h0);
        step();
        chk("sk_n3_irq",   32'(irq),   32'h1);
        chk("sk_n3_data",  32'(data),  32'h1E);
        rd_port(20'h00060);
        chk("sk_rd_sel",   32'(sel),   32'h1);
        chk("sk_rd_data",  32'(data),  32'h1E);
        chk("sk_rd_irq",   32'(irq),   32'h1);
        step();
        chk("sk_sel_drop", 32'(sel),   32'h0);
        chk("sk_irq_stay", 32'(irq),   32'h1);
        wr_port(20'h00061, 8'h80);
        chk("sk_ack_irq",  32'(irq),   32'h0);
        chk("sk_ack_data", 32'(data),  32'h00);
        wr_port(20'h00061, 8'h00);
        chk("sk_rel_irq",  32'(irq),   32'h0);
        chk("sk_rel_cnt",  32'(count), 32'd0);
        step();
        chk("sk_idle_irq", 32'(irq),   32'h0);

        // Queueing: three back-to-back strobes
        code_valid = 1'b1;
        code = 8'h1E; step();
        code = 8'h9E; step();
        code = 8'h2A; step();
        code_valid = 1'b0;
        code = 8'h00;
        chk("q1_irq",   32'(irq),   32'h1);
        chk("q1_data",  32'(data),  32'h1E);
        chk("q1_count", 32'(count), 32'd2);
        wr_port(20'h00061, 8'h80);
        chk("q1_hold_irq", 32'(irq), 32'h0);
        wr_port(20'h00061, 8'h00);
        chk("q2_load_irq", 32'(irq),   32'h0);
        chk("q2_load_cnt", 32'(count), 32'd1);
        step();
        chk("q2_irq",   32'(irq),   32'h1);
        chk("q2_data",  32'(data),  32'h9E);
        wr_port(20'h00061, 8'h80);
        wr_port(20'h00061, 8'h00);
        chk("q3_load_cnt", 32'(count), 32'd0);
        step();
        chk("q3_irq",   32'(irq),   32'h1);
        chk("q3_data",  32'(data),  32'h2A);
        wr_port(20'h00061, 8'h80);
        wr_port(20'h00061, 8'h00);
        step();
        chk("q_end_irq", 32'(irq),   32'h0);
        chk("q_end_cnt", 32'(count), 32'd0);

        // Overflow: ten codes while held; only the first eight survive
        wr_port(20'h00061, 8'h80);
        chk("ov_hold_irq", 32'(irq), 32'h0);
        code_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            code = 8'(i);
            step();
        end
        code_valid = 1'b0;
        code = 8'h00;
        chk("ov_count", 32'(count), 32'd8);
        chk("ov_flag",  32'(ovf),   32'h1);
        chk("ov_irq",   32'(irq),   32'h0);
        chk("ov_data",  32'(data),  32'h00);
        for (int i = 1; i <= 8; i++) begin
            wr_port(20'h00061, 8'h00);
            chk($sformatf("ov_load_irq_%0d", i), 32'(irq), 32'h0);
            step();
            chk($sformatf("ov_irq_%0d", i),  32'(irq),   32'h1);
            chk($sformatf("ov_data_%0d", i), 32'(data),  32'(i));
            chk($sformatf("ov_cnt_%0d", i),  32'(count), 32'(8 - i));
            wr_port(20'h00061, 8'h80);
        end
        wr_port(20'h00061, 8'h00);
        step();
        step();
        chk("ov_drained_irq", 32'(irq),  32'h0);
        chk("ov_drained_dat", 32'(data), 32'h00);
        chk("ov_sticky",      32'(ovf),  32'h1);

        // Simultaneous push/pop on a full FIFO
        do_reset();
        chk("pp_rst_ovf", 32'(ovf), 32'h0);
        wr_port(20'h00061, 8'h80);
        code_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            code = 8'(8'h11 + i);
            step();
        end
        code_valid = 1'b0;
        chk("pp_full_cnt", 32'(count), 32'd8);
        wr      = 1'b1;
        addr    = 20'h00061;
        wr_data = 8'h00;
        code_valid = 1'b1;
        code    = 8'h55;
        step();
        wr = 1'b0; addr = '0; code_valid = 1'b0; code = 8'h00;
        chk("pp_cnt",  32'(count), 32'd8);
        chk("pp_ovf",  32'(ovf),   32'h0);
        chk("pp_irq0", 32'(irq),   32'h0);
        step();
        chk("pp_irq1",  32'(irq),  32'h1);
        chk("pp_data1", 32'(data), 32'h11);
        exp_codes[0] = 8'h12; exp_codes[1] = 8'h13; exp_codes[2] = 8'h14;
        exp_codes[3] = 8'h15; exp_codes[4] = 8'h16; exp_codes[5] = 8'h17;
        exp_codes[6] = 8'h18; exp_codes[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            wr_port(20'h00061, 8'h80);
            wr_port(20'h00061, 8'h00);
            step();
            chk($sformatf("pp_data_%0d", i), 32'(data), 32'(exp_codes[i]));
        end
        wr_port(20'h00061, 8'h80);
        wr_port(20'h00061, 8'h00);
        step();
        chk("pp_end_irq", 32'(irq),   32'h0);
        chk("pp_end_cnt", 32'(count), 32'd0);
        chk("pp_end_ovf", 32'(ovf),   32'h0);

        // Reset in PRESENT with three codes queued
        code_valid = 1'b1;
        code = 8'h21; step();
        code = 8'h22; step();
        code = 8'h23; step();
        code = 8'h24; step();
        code_valid = 1'b0;
        chk("mr_irq",  32'(irq),   32'h1);
        chk("mr_data", 32'(data),  32'h21);
        chk("mr_cnt",  32'(count), 32'd3);
        rst = 1'b1; rd = 1'b1; addr = 20'h00060;
        code_valid = 1'b1; code = 8'h77;
        step();
        rst = 1'b0; rd = 1'b0; addr = '0; code_valid = 1'b0; code = 8'h00;
        chk_reset_vals("mr");
        strobe(8'h39);
        chk("mr_n1_cnt", 32'(count), 32'd1);
        step();
        chk("mr_n2_cnt", 32'(count), 32'd0);
        chk("mr_n2_irq", 32'(irq),   32'h0);
        step();
        chk("mr_n3_irq",  32'(irq),  32'h1);
        chk("mr_n3_data", 32'(data), 32'h39);

        // Decode filtering
        wr_port(20'h00062, 8'h80);
        chk("df_wr_irq",  32'(irq),  32'h1);
        chk("df_wr_data", 32'(data), 32'h39);
        chk("df_wr_sel",  32'(sel),  32'h0);
        rd_port(20'h00061);
        chk("df_rd_sel",  32'(sel),  32'h0);
        chk("df_rd_irq",  32'(irq),  32'h1);
        rd_port(20'h30060);
        chk("df_hi_sel",  32'(sel),  32'h1);
        chk("df_hi_irq",  32'(irq),  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
